// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (D/E, E/M, M/W) with stall, flush, Tnew ageing
// and pre-decoded hazard qualifiers. Define PIPE_STAGE_PERF_EN to add stall/flush counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned TNEW_W   = 4,
  parameter int unsigned TNEW_DEC = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [31:0]               in_pc,
  input  logic [DATA_W-1:0]         in_payload,
  input  logic                      in_reg_write,
  input  logic [ADDR_W-1:0]         in_a3,
  input  logic [NUM_SRC*ADDR_W-1:0] in_src_addr,
  input  logic [NUM_SRC-1:0]        in_src_use,
  input  logic [TNEW_W-1:0]         in_tnew,
  output logic                      out_valid,
  output logic [31:0]               out_pc,
  output logic [DATA_W-1:0]         out_payload,
  output logic                      out_reg_write,
  output logic [ADDR_W-1:0]         out_a3,
  output logic [NUM_SRC*ADDR_W-1:0] out_src_addr,
  output logic [NUM_SRC-1:0]        out_src_use,
  output logic [TNEW_W-1:0]         out_tnew,
  output logic [ADDR_W-1:0]         out_a3_eff,
  output logic                      out_fwd_avail
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  typedef struct packed {
    logic                      valid;
    logic [31:0]               pc;
    logic [DATA_W-1:0]         payload;
    logic                      reg_write;
    logic [ADDR_W-1:0]         a3;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_use;
    logic [TNEW_W-1:0]         tnew;
  } stage_t;

  stage_t            stage_q;
  stage_t            load_d;
  logic [TNEW_W-1:0] tnew_aged;

  // Tnew ages by one cycle on the way in and bottoms out at zero instead of wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    tnew_aged = in_tnew;
    if ((TNEW_DEC != 0) && (in_tnew != '0)) tnew_aged = in_tnew - TNEW_W'(1);
  end

  assign load_d = '{
    valid:     in_valid,
    pc:        in_pc,
    payload:   in_payload,
    reg_write: in_reg_write,
    a3:        in_a3,
    src_addr:  in_src_addr,
    src_use:   in_src_use,
    tnew:      tnew_aged
  };

  // A flush is a bubble: the same all-zero image as reset, and it wins over a stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset || flush) stage_q <= '0;
    else if (!stall)    stage_q <= load_d;
  end

  assign out_valid     = stage_q.valid;
  assign out_pc        = stage_q.pc;
  assign out_payload   = stage_q.payload;
  assign out_reg_write = stage_q.reg_write;
  assign out_a3        = stage_q.a3;
  assign out_src_addr  = stage_q.src_addr;
  assign out_src_use   = stage_q.src_use;
  assign out_tnew      = stage_q.tnew;

  // Qualifiers come only from registered state; invalid slots and r0 never look like producers.
  assign out_a3_eff    = (stage_q.valid && stage_q.reg_write) ? stage_q.a3 : '0;
  assign out_fwd_avail = stage_q.valid && stage_q.reg_write &&
                         (stage_q.a3 != '0) && (stage_q.tnew == '0);

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !flush && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != '1))           flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: default instance plus a NUM_SRC=3/ADDR_W=6/TNEW_DEC=0 instance,
// directed steps followed by random traffic against a field-level reference model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [63:0] payload;
    logic        rw;
    logic [5:0]  a3;
    logic [17:0] src;
    logic [2:0]  use_b;
    logic [3:0]  tnew;
  } rec_t;

  logic clk = 1'b0;
  logic reset, stall, flush;
  int   checks = 0;
  int   failures = 0;

  rec_t in0, in1, e0, e1, obs0, obs1;

  logic [4:0]  a3_eff0;
  logic [5:0]  a3_eff1;
  logic        fwd0, fwd1;
  logic [4:0]  o_a3_0;
  logic [9:0]  o_src0;
  logic [1:0]  o_use0;
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] exp_stall_cnt, exp_flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in0.valid), .in_pc(in0.pc), .in_payload(in0.payload),
    .in_reg_write(in0.rw), .in_a3(in0.a3[4:0]), .in_src_addr(in0.src[9:0]),
    .in_src_use(in0.use_b[1:0]), .in_tnew(in0.tnew),
    .out_valid(obs0.valid), .out_pc(obs0.pc), .out_payload(obs0.payload),
    .out_reg_write(obs0.rw), .out_a3(o_a3_0), .out_src_addr(o_src0),
    .out_src_use(o_use0), .out_tnew(obs0.tnew),
    .out_a3_eff(a3_eff0), .out_fwd_avail(fwd0)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  assign obs0.a3    = {1'b0, o_a3_0};
  assign obs0.src   = {8'b0, o_src0};
  assign obs0.use_b = {1'b0, o_use0};

  pipe_stage_reg #(.DATA_W(64), .ADDR_W(6), .NUM_SRC(3), .TNEW_W(4), .TNEW_DEC(0)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in1.valid), .in_pc(in1.pc), .in_payload(in1.payload),
    .in_reg_write(in1.rw), .in_a3(in1.a3), .in_src_addr(in1.src),
    .in_src_use(in1.use_b), .in_tnew(in1.tnew),
    .out_valid(obs1.valid), .out_pc(obs1.pc), .out_payload(obs1.payload),
    .out_reg_write(obs1.rw), .out_a3(obs1.a3), .out_src_addr(obs1.src),
    .out_src_use(obs1.use_b), .out_tnew(obs1.tnew),
    .out_a3_eff(a3_eff1), .out_fwd_avail(fwd1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(), .flush_cnt()
`endif
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour: reset/flush give a bubble, stall keeps, load copies and ages Tnew.
  function automatic rec_t model(input rec_t cur, input rec_t inp, input bit rst, input bit fl,
                                 input bit st, input bit dec);
    rec_t n;
    if (rst || fl)   n = '0;
    else if (st)     n = cur;
    else begin
      n = inp;
      if (dec && inp.tnew != 4'd0) n.tnew = inp.tnew - 4'd1;
    end
    return n;
  endfunction

  task automatic compare(input string tag, input rec_t exp, input rec_t obs,
                         input logic [5:0] obs_eff, input logic obs_fwd);
    logic [5:0] exp_eff;
    logic       exp_fwd;
    exp_eff = (exp.valid && exp.rw) ? exp.a3 : 6'd0;
    exp_fwd = exp.valid && exp.rw && (exp.a3 != 6'd0) && (exp.tnew == 4'd0);
    check({tag, ".valid"},   64'(obs.valid),   64'(exp.valid));
    check({tag, ".pc"},      64'(obs.pc),      64'(exp.pc));
    check({tag, ".payload"}, obs.payload,      exp.payload);
    check({tag, ".rw"},      64'(obs.rw),      64'(exp.rw));
    check({tag, ".a3"},      64'(obs.a3),      64'(exp.a3));
    check({tag, ".src"},     64'(obs.src),     64'(exp.src));
    check({tag, ".use"},     64'(obs.use_b),   64'(exp.use_b));
    check({tag, ".tnew"},    64'(obs.tnew),    64'(exp.tnew));
    check({tag, ".a3_eff"},  64'(obs_eff),     64'(exp_eff));
    check({tag, ".fwd"},     64'(obs_fwd),     64'(exp_fwd));
  endtask

  task automatic step(input string tag, input bit rst, input bit fl, input bit st);
    reset = rst; flush = fl; stall = st;
    e0 = model(e0, in0, rst, fl, st, 1'b1);
    e1 = model(e1, in1, rst, fl, st, 1'b0);
    if (rst) begin
      exp_stall_cnt = 0; exp_flush_cnt = 0;
    end else begin
      if (st && !fl && exp_stall_cnt != 32'hFFFF_FFFF) exp_stall_cnt++;
      if (fl && exp_flush_cnt != 32'hFFFF_FFFF)        exp_flush_cnt++;
    end
    @(posedge clk);
    #1;
    compare({tag, "/d0"}, e0, obs0, {1'b0, a3_eff0}, fwd0);
    compare({tag, "/d1"}, e1, obs1, a3_eff1, fwd1);
`ifdef PIPE_STAGE_PERF_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(exp_stall_cnt));
    check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(exp_flush_cnt));
`endif
  endtask

  task automatic rand_in();
    in0.valid = 1'($urandom);           in1.valid = 1'($urandom);
    in0.pc    = $urandom;               in1.pc    = $urandom;
    in0.payload = {$urandom, $urandom}; in1.payload = {$urandom, $urandom};
    in0.rw    = 1'($urandom);           in1.rw    = 1'($urandom);
    in0.a3    = 6'($urandom_range(0, 31));
    in1.a3    = 6'($urandom_range(0, 63));
    in0.src   = 18'($urandom_range(0, 1023));
    in1.src   = 18'($urandom);
    in0.use_b = 3'($urandom_range(0, 3));
    in1.use_b = 3'($urandom);
    in0.tnew  = 4'($urandom);           in1.tnew  = 4'($urandom);
  endtask

  // Directed instruction for the default instance; other fields stay random.
  task automatic set0(input logic v, input logic [31:0] pc, input logic rw,
                      input logic [5:0] a3, input logic [3:0] tnew);
    rand_in();
    in0.valid = v; in0.pc = pc; in0.rw = rw; in0.a3 = a3; in0.tnew = tnew;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in0 = '0; in1 = '0; e0 = '0; e1 = '0;
    exp_stall_cnt = 0; exp_flush_cnt = 0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;

    rand_in();
    step("reset1", 1'b1, 1'b0, 1'b0);
    step("reset2", 1'b1, 1'b0, 1'b1);
    check("reset.pc", 64'(obs0.pc), 64'd0);

    set0(1'b1, 32'h3000, 1'b1, 6'd8, 4'd2);
    step("load", 1'b0, 1'b0, 1'b0);
    check("load.pc_const",   64'(obs0.pc), 64'h3000);
    check("load.a3eff_const", 64'(a3_eff0), 64'd8);
    check("load.tnew_const", 64'(obs0.tnew), 64'd1);
    check("load.fwd_const",  64'(fwd0), 64'd0);

    set0(1'b1, 32'h3004, 1'b1, 6'd3, 4'd0);
    step("tnew0", 1'b0, 1'b0, 1'b0);
    check("tnew0.fwd_const", 64'(fwd0), 64'd1);
    set0(1'b1, 32'h3008, 1'b1, 6'd3, 4'd1);
    step("tnew1", 1'b0, 1'b0, 1'b0);
    check("tnew1.tnew_const", 64'(obs0.tnew), 64'd0);

    set0(1'b1, 32'h300C, 1'b1, 6'd4, 4'd3);
    step("pre_stall", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rand_in();
      step("stall", 1'b0, 1'b0, 1'b1);
      check("stall.tnew_const", 64'(obs0.tnew), 64'd2);
    end

    set0(1'b1, 32'h3010, 1'b1, 6'd9, 4'd1);
    step("hold9", 1'b0, 1'b0, 1'b0);
    rand_in();
    step("flush_stall", 1'b0, 1'b1, 1'b1);
    check("flush.valid_const", 64'(obs0.valid), 64'd0);
    rand_in();
    step("flush_again", 1'b0, 1'b1, 1'b1);
    rand_in();
    step("stall_after_flush", 1'b0, 1'b0, 1'b1);

    set0(1'b1, 32'h3014, 1'b1, 6'd0, 4'd0);
    step("r0", 1'b0, 1'b0, 1'b0);
    check("r0.fwd_const", 64'(fwd0), 64'd0);
    set0(1'b0, 32'h3018, 1'b1, 6'd7, 4'd0);
    step("invalid", 1'b0, 1'b0, 1'b0);
    check("invalid.a3eff_const", 64'(a3_eff0), 64'd0);
    check("invalid.a3_const", 64'(obs0.a3), 64'd7);

    set0(1'b1, 32'h301C, 1'b1, 6'd12, 4'd15);
    in1.src = {6'd3, 6'd2, 6'd1}; in1.use_b = 3'b101; in1.tnew = 4'd5;
    step("tnew_max", 1'b0, 1'b0, 1'b0);
    check("tnew_max.tnew_const", 64'(obs0.tnew), 64'd14);
    check("sweep.src_const", 64'(obs1.src), 64'h3081);
    check("sweep.use_const", 64'(obs1.use_b), 64'd5);
    check("sweep.tnew_const", 64'(obs1.tnew), 64'd5);

    rand_in();
    step("stall_pre_rst", 1'b0, 1'b0, 1'b1);
    rand_in();
    step("rst_mid_stall", 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      rand_in();
      step("random", r < 3, (r >= 3) && (r < 13), (r >= 10) && (r < 40));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. It replaces the hand-written per-stage registers: D/E, E/M and M/W are each one instance.
- Carries these fields between stages:
  - valid bit
  - PC
  - opaque control/data payload
  - destination register and its write enable
  - NUM_SRC source-register fields with use bits
  - Tnew counter
- Implements stall (hold), flush (bubble) and saturating Tnew ageing.
- Emits pre-decoded forwarding/hazard qualifiers so the hazard unit needs no per-stage glue.

Parameters:
- DATA_W, 64, width of opaque payload bus (control signals, operands, immediates).
- ADDR_W, 5, register-address width.
- NUM_SRC, 2, number of source-register channels (A1, A2, ...).
- TNEW_W, 4, width of the Tnew counter.
- TNEW_DEC, 1:
  - 1: Tnew decrements (saturating at 0) on every load.
  - 0: Tnew is passed through unchanged.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current contents
- flush  in  1  load a bubble
- in_valid  in  1  upstream instruction valid
- in_pc  in  32  upstream PC
- in_payload  in  DATA_W  upstream control/data bundle
- in_reg_write  in  1  instruction writes a GPR
- in_a3  in  ADDR_W  destination register
- in_src_addr  in  NUM_SRC*ADDR_W  source registers; channel k is at bits [k*ADDR_W +: ADDR_W]
- in_src_use  in  NUM_SRC  bit k set means channel k is read
- in_tnew  in  TNEW_W  cycles until result is produced, as seen at the input stage
- out_valid  out  1  registered valid
- out_pc  out  32  registered PC
- out_payload  out  DATA_W  registered payload
- out_reg_write  out  1  registered write enable
- out_a3  out  ADDR_W  registered destination register
- out_src_addr  out  NUM_SRC*ADDR_W  registered source registers
- out_src_use  out  NUM_SRC  registered use bits
- out_tnew  out  TNEW_W  registered (aged) Tnew
- out_a3_eff  out  ADDR_W  effective destination for hazard compare (combinational from registers)
- out_fwd_avail  out  1  result in this stage may be forwarded now (combinational from registers)

Behaviour:
- All state updates occur on posedge clk. Update priority is reset > flush > stall > load.
- Reset: every registered output is 0, i.e. out_valid, out_pc, out_payload, out_reg_write, out_a3, out_src_addr, out_src_use and out_tnew. Consequently out_a3_eff=0 and out_fwd_avail=0.
- Flush (reset=0, flush=1):
  - Next state is identical to the reset state (bubble).
  - Flush overrides a simultaneous stall.
  - A bubble never requests forwarding and never causes a stall.
- Stall (reset=0, flush=0, stall=1): all registers hold their values, including out_tnew (no ageing while held).
- Load (reset=0, flush=0, stall=0): every out_* field takes the corresponding in_* field, one-cycle latency, except out_tnew:
  - TNEW_DEC=1: out_tnew = (in_tnew==0) ? 0 : in_tnew-1. Saturating, never wraps to all-ones.
  - TNEW_DEC=0: out_tnew = in_tnew.
- Load when in_valid=0:
  - Fields are stored as presented.
  - out_a3_eff and out_fwd_avail are still forced 0 by the valid gate (see below).
- out_a3_eff = (out_valid && out_reg_write) ? out_a3 : 0. Register 0 is therefore never a hazard target.
- out_fwd_avail = out_valid && out_reg_write && (out_a3 != 0) && (out_tnew == 0).
- Boundary cases:
  - in_tnew = 2^TNEW_W-1: decrements normally.
  - stall held for N cycles: contents identical for all N cycles.
  - reset asserted mid-stall: clears on the next edge.
  - stall and flush both high on consecutive cycles: each cycle is resolved independently by the priority rule.
- No combinational path from any input to any output.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, two extra ports are added:
  - stall_cnt  out  32
  - flush_cnt  out  32
- Counter rules:
  - stall_cnt increments on each clock with stall=1 and flush=0 and reset=0.
  - flush_cnt increments on each clock with flush=1 and reset=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When not defined: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then load:
  - Stimulus: reset=1 for 2 cycles, then load in_valid=1, in_pc=32'h3000, in_reg_write=1, in_a3=5'd8, in_tnew=2.
  - Required: all outputs 0 during reset; next cycle out_pc=32'h3000, out_a3_eff=8, out_tnew=1, out_fwd_avail=0.
- Tnew saturation:
  - Stimulus: load in_tnew=0, then in_tnew=1, with in_reg_write=1, in_a3=3, in_valid=1.
  - Required: out_tnew=0 both times; out_fwd_avail=1 both times.
- Stall hold:
  - Stimulus: load in_tnew=3, then stall=1 for 4 cycles while inputs change randomly.
  - Required: out_tnew stays 2 and all fields are unchanged for all 4 cycles; PIPE_STAGE_PERF_EN build shows stall_cnt=4.
- Flush beats stall:
  - Stimulus: stall=1 and flush=1 together on a stage holding valid a3=9.
  - Required: next cycle all outputs 0, out_a3_eff=0; perf build shows flush_cnt=1, stall_cnt unchanged.
- Register-0 and invalid gating:
  - Stimulus: load in_a3=0, in_reg_write=1, in_tnew=0, then load in_valid=0, in_a3=7, in_reg_write=1.
  - Required: out_fwd_avail=0 and out_a3_eff=0 in both cases.
- Parameter sweep:
  - Stimulus: NUM_SRC=3, ADDR_W=6, TNEW_DEC=0; load in_src_addr={6'd3,6'd2,6'd1}, in_src_use=3'b101, in_tnew=5.
  - Required: fields pass through bit-exact; out_tnew=5.
